uart_rx_fifo: RTL



---
 rtl/uart_rx_fifo.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver (LSB first, idle-high line) feeding a show-ahead receive FIFO
// with a ready/valid byte output and sticky framing/overrun flags.
module uart_rx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 234,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx_in,
  output logic                          m_valid,
  output logic [7:0]                    m_data,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          rx_busy,
  output logic                          frame_err,
  output logic                          overrun,
  input  logic                          err_clr
);

  localparam int unsigned CW   = $clog2(CLKS_PER_BIT);
  localparam int unsigned HALF = CLKS_PER_BIT / 2;
  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam int unsigned PW   = AW + 1;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HI} state_t;

  state_t          state, state_next;
  logic [1:0]      sync;
  logic            rxs;
  logic [CW-1:0]   cnt;
  logic [2:0]      idx;
  logic [7:0]      shreg;
  logic            half_tick, bit_tick;
  logic            cnt_clr, cnt_run, shift_en, push_req, set_fe;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr, wr_next, rd_next;
  logic            full, empty, push, pop;

  assign rxs       = sync[1];
  assign half_tick = (cnt == CW'(HALF - 1));
  assign bit_tick  = (cnt == CW'(CLKS_PER_BIT - 1));

  // Two-flop synchronizer; resets to the idle-high level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= 2'b11;
    else     sync <= {sync[0], rx_in};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!rxs) state_next = START;
      START:   if (half_tick) state_next = rxs ? IDLE : DATA;
      DATA:    if (bit_tick && idx == 3'd7) state_next = STOP;
      STOP:    if (bit_tick) state_next = rxs ? IDLE : WAIT_HI;
      WAIT_HI: if (rxs) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cnt_clr  = 1'b0;
    cnt_run  = 1'b0;
    shift_en = 1'b0;
    push_req = 1'b0;
    set_fe   = 1'b0;
    case (state)
      START: begin
        cnt_run = 1'b1;
        cnt_clr = half_tick;
      end
      DATA: begin
        cnt_run  = 1'b1;
        cnt_clr  = bit_tick;
        shift_en = bit_tick;
      end
      STOP: begin
        cnt_run  = 1'b1;
        cnt_clr  = bit_tick;
        push_req = bit_tick & rxs;
        set_fe   = bit_tick & ~rxs;
      end
      default: cnt_clr = 1'b1;
    endcase
  end

  // Bit timing counter, bit index and LSB-first shift register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      idx     <= '0;
      shreg   <= '0;
      rx_busy <= 1'b0;
    end else begin
      if (cnt_clr)      cnt <= '0;
      else if (cnt_run) cnt <= cnt + CW'(1);
      if (state != DATA) idx <= '0;
      else if (shift_en) idx <= idx + 3'd1;
      if (shift_en) shreg <= {rxs, shreg[7:1]};
      rx_busy <= (state_next != IDLE);
    end
  end

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = m_ready & ~empty;
  assign push    = push_req & (~full | pop);
  assign wr_next = wr_ptr + PW'(push);
  assign rd_next = rd_ptr + PW'(pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= shreg;
  end

  // Head register tracks next pointers; bypass when the pushed byte becomes the head
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      m_valid    <= 1'b0;
      m_data     <= 8'h00;
      fifo_count <= '0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      wr_ptr     <= wr_next;
      rd_ptr     <= rd_next;
      m_valid    <= (wr_next != rd_next);
      fifo_count <= wr_next - rd_next;
      if (push && wr_ptr == rd_next) m_data <= shreg;
      else                           m_data <= mem[rd_next[AW-1:0]];
      if (set_fe)       frame_err <= 1'b1;
      else if (err_clr) frame_err <= 1'b0;
      if (push_req && full && !pop) overrun <= 1'b1;
      else if (err_clr)             overrun <= 1'b0;
    end
  end

endmodule
